axi_stream_mem_responder: RTL and testbench

//  Memory-side responder for the kernel read and write stream adapters.
//  - Consumes single-beat read requests (address only) and returns one payload beat per request, in order.
//  - Consumes single-beat write beats carrying {addr,data} and commits them to an on-chip single-port RAM.
//  - Sits at the far end of the read-request, payload and write streams; stands in for external memory in kernel testbenches and small builds.

---
 rtl/axi_stream_mem_responder.sv | 126 ++++++++++++
 tb/tb_axi_stream_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_mem_responder.sv
// Memory-side stream responder: single-port RAM fed by a write stream and a read-request stream.
// It returns read payloads in order through a 2-entry response FIFO, and writes win arbitration until a read has waited STARVE_LIMIT cycles.
module axi_stream_mem_responder #(
    parameter int ADDR_WIDTH   = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            s_axis_req_tdata,
    input  logic                             s_axis_req_tvalid,
    output logic                             s_axis_req_tready,
    input  logic                             s_axis_req_tlast,
    output logic [DATA_WIDTH-1:0]            m_axis_pl_tdata,
    output logic                             m_axis_pl_tvalid,
    input  logic                             m_axis_pl_tready,
    output logic                             m_axis_pl_tlast,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_wr_tdata,
    input  logic                             s_axis_wr_tvalid,
    output logic                             s_axis_wr_tready,
    input  logic                             s_axis_wr_tlast,
    output logic                             err_oob
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [SC_W-1:0]     STARVE_MAX = SC_W'(STARVE_LIMIT);

    function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= DEPTH_L;
    endfunction

    logic [DATA_WIDTH-1:0] ram_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic [DATA_WIDTH-1:0] fifo_mem [2];

    logic [1:0]      fifo_count_q, fifo_count_d;
    logic            fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic            fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic            rd_vld_p1_q, rd_vld_p1_d;
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic            err_oob_q, err_oob_d;

    logic                  rd_ok, wr_grant, rd_grant;
    logic                  fifo_push, fifo_pop;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_wdata;
    logic                  unused_tlast;

    assign wr_addr      = s_axis_wr_tdata[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
    assign wr_wdata     = s_axis_wr_tdata[DATA_WIDTH-1:0];
    assign unused_tlast = s_axis_req_tlast ^ s_axis_wr_tlast;

    // Arbitration and control next-state
    always_comb begin
        rd_ok    = s_axis_req_tvalid && ((fifo_count_q + {1'b0, rd_vld_p1_q}) < 2'd2);
        wr_grant = s_axis_wr_tvalid && (!rd_ok || (starve_cnt_q < STARVE_MAX));
        rd_grant = rd_ok && !wr_grant;

        fifo_push = rd_vld_p1_q;
        fifo_pop  = (fifo_count_q != 2'd0) && m_axis_pl_tready;

        starve_cnt_d = starve_cnt_q;
        if (rd_grant) begin
            starve_cnt_d = '0;
        end else if (rd_ok && wr_grant && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        err_oob_d = err_oob_q
                  | (wr_grant && addr_oob(wr_addr))
                  | (rd_grant && addr_oob(s_axis_req_tdata));

        rd_vld_p1_d   = rd_grant;
        fifo_wr_ptr_d = fifo_wr_ptr_q ^ fifo_push;
        fifo_rd_ptr_d = fifo_rd_ptr_q ^ fifo_pop;

        fifo_count_d = fifo_count_q;
        if (fifo_push && !fifo_pop) begin
            fifo_count_d = fifo_count_q + 2'd1;
        end else if (!fifo_push && fifo_pop) begin
            fifo_count_d = fifo_count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count_q  <= 2'd0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            rd_vld_p1_q   <= 1'b0;
            starve_cnt_q  <= '0;
            err_oob_q     <= 1'b0;
        end else begin
            fifo_count_q  <= fifo_count_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            rd_vld_p1_q   <= rd_vld_p1_d;
            starve_cnt_q  <= starve_cnt_d;
            err_oob_q     <= err_oob_d;
        end
    end

    // p0 -> p1: RAM write commit and synchronous read; p1 -> FIFO: push of the read word
    always_ff @(posedge clk) begin
        if (wr_grant && !addr_oob(wr_addr)) begin
            ram_mem[wr_addr[IDX_W-1:0]] <= wr_wdata;
        end
        if (rd_grant) begin
            rd_data_p1 <= addr_oob(s_axis_req_tdata) ? '0 : ram_mem[s_axis_req_tdata[IDX_W-1:0]];
        end
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr_q] <= rd_data_p1;
        end
    end

    assign s_axis_wr_tready  = wr_grant;
    assign s_axis_req_tready = rd_grant;
    assign m_axis_pl_tvalid  = (fifo_count_q != 2'd0);
    assign m_axis_pl_tdata   = m_axis_pl_tvalid ? fifo_mem[fifo_rd_ptr_q] : '0;
    assign m_axis_pl_tlast   = 1'b1;
    assign err_oob           = err_oob_q;

endmodule

// File: tb/tb_axi_stream_mem_responder.sv
// Bench for axi_stream_mem_responder (DEPTH=3 so out-of-range addresses are reachable).
// A reference memory predicts each read payload at request accept; delivered beats are compared in order.
module tb_axi_stream_mem_responder;

    localparam int AW    = 2;
    localparam int DW    = 64;
    localparam int DEPTH = 3;
    localparam int SL    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [AW-1:0]      req_data;
    logic               req_valid, req_ready, req_last;
    logic [DW-1:0]      pl_data;
    logic               pl_valid, pl_ready, pl_last;
    logic [AW+DW-1:0]   wr_data;
    logic               wr_valid, wr_ready, wr_last;
    logic               err_oob;

    axi_stream_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_req_tdata(req_data), .s_axis_req_tvalid(req_valid),
        .s_axis_req_tready(req_ready), .s_axis_req_tlast(req_last),
        .m_axis_pl_tdata(pl_data), .m_axis_pl_tvalid(pl_valid),
        .m_axis_pl_tready(pl_ready), .m_axis_pl_tlast(pl_last),
        .s_axis_wr_tdata(wr_data), .s_axis_wr_tvalid(wr_valid),
        .s_axis_wr_tready(wr_ready), .s_axis_wr_tlast(wr_last),
        .err_oob(err_oob)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW:0]   got_q [$];

    logic obs_wr, obs_rd, obs_pl_valid, obs_req_ready;

    // One clock: observe handshakes at the falling edge, update the model, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        obs_wr        = wr_valid && wr_ready;
        obs_rd        = req_valid && req_ready;
        obs_pl_valid  = pl_valid;
        obs_req_ready = req_ready;
        if (pl_valid && pl_ready) got_q.push_back({pl_last, pl_data});
        if (obs_rd) exp_q.push_back((int'(req_data) < DEPTH) ? mdl_mem[req_data] : '0);
        if (obs_wr && (int'(wr_data[AW+DW-1 -: AW]) < DEPTH))
            mdl_mem[wr_data[AW+DW-1 -: AW]] = wr_data[DW-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = {a, d};
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW:0] beat;
        rst = 1'b1; req_valid = 1'b0; wr_valid = 1'b0; pl_ready = 1'b1;
        req_data = '0; wr_data = '0; req_last = 1'b1; wr_last = 1'b1;
        step(); step();
        rst = 1'b0;
        n_cmp++;
        if (pl_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", pl_valid); end
        n_cmp++;
        if (pl_data !== '0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", pl_data); end
        n_cmp++;
        if (err_oob !== 1'b0) begin n_bad++; $display("FAIL reset_err_oob: got %b want 0", err_oob); end
        n_cmp++;
        if (pl_last !== 1'b1) begin n_bad++; $display("FAIL reset_tlast: got %b want 1", pl_last); end
        beat = '0;
    endtask

    task automatic test_write_read();
        logic [DW:0] beat;
        logic [DW-1:0] want;
        do_write(2'd1, 64'hDEAD_BEEF);
        n_cmp++;
        if (obs_wr !== 1'b1) begin n_bad++; $display("FAIL wr_accept: got %b want 1", obs_wr); end
        req_valid = 1'b1; req_data = 2'd1;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (obs_rd !== 1'b1) begin n_bad++; $display("FAIL rd_accept: got %b want 1", obs_rd); end
        step();
        n_cmp++;
        if (obs_pl_valid !== 1'b0) begin n_bad++; $display("FAIL latency_t1_tvalid: got %b want 0", obs_pl_valid); end
        step();
        n_cmp++;
        if (obs_pl_valid !== 1'b1) begin n_bad++; $display("FAIL latency_t2_tvalid: got %b want 1", obs_pl_valid); end
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL wr_rd_count: got %0d beats want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat = got_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (beat !== {1'b1, want}) begin n_bad++; $display("FAIL wr_rd_payload: got %h want %h", beat, {1'b1, want}); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_collision();
        logic [DW:0] beat;
        logic [DW-1:0] want;
        do_write(2'd2, 64'h0000_0000_0BAD_0001);
        wr_valid = 1'b1; wr_data = {2'd2, 64'h1111_2222_3333_4444};
        req_valid = 1'b1; req_data = 2'd2;
        step();
        wr_valid = 1'b0;
        n_cmp++;
        if ({obs_wr, obs_rd} !== 2'b10) begin n_bad++; $display("FAIL collision_grant: got wr/rd %b want 10", {obs_wr, obs_rd}); end
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (obs_rd !== 1'b1) begin n_bad++; $display("FAIL collision_rd_next: got %b want 1", obs_rd); end
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL collision_count: got %0d beats want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat = got_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (beat !== {1'b1, want}) begin n_bad++; $display("FAIL collision_payload: got %h want %h", beat, {1'b1, want}); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_starvation();
        logic [DW:0] beat;
        logic [DW-1:0] want;
        logic [6:0] wr_bits, rd_bits;
        req_valid = 1'b1; req_data = 2'd0;
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_data  = {AW'(i % 2), 64'h100 + 64'(i)};
            step();
            wr_bits[i] = obs_wr;
            rd_bits[i] = obs_rd;
            if (obs_rd) req_valid = 1'b0;
        end
        wr_valid = 1'b0; req_valid = 1'b0;
        n_cmp++;
        if (rd_bits !== 7'b0010000) begin n_bad++; $display("FAIL starve_rd_grants: got %b want 0010000", rd_bits); end
        n_cmp++;
        if (wr_bits !== 7'b1101111) begin n_bad++; $display("FAIL starve_wr_grants: got %b want 1101111", wr_bits); end
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL starve_count: got %0d beats want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat = got_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (beat !== {1'b1, want}) begin n_bad++; $display("FAIL starve_payload: got %h want %h", beat, {1'b1, want}); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [DW:0] beat;
        logic [DW-1:0] want;
        logic [AW-1:0] addrs [3];
        int n_acc;
        addrs[0] = 2'd2; addrs[1] = 2'd0; addrs[2] = 2'd1;
        n_acc = 0;
        pl_ready = 1'b0; req_valid = 1'b1; req_data = addrs[0];
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_rd) begin
                n_acc++;
                if (n_acc < 3) req_data = addrs[n_acc];
            end
        end
        n_cmp++;
        if (n_acc != 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", n_acc); end
        n_cmp++;
        if (obs_req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_tready: got %b want 0", obs_req_ready); end
        n_cmp++;
        if (!(pl_valid === 1'b1 && exp_q.size() > 0 && pl_data === exp_q[0])) begin
            n_bad++; $display("FAIL bp_head_stable: got valid %b data %h", pl_valid, pl_data);
        end
        pl_ready = 1'b1;
        for (int i = 0; i < 10 && n_acc < 3; i++) begin
            step();
            if (obs_rd) n_acc++;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (n_acc != 3) begin n_bad++; $display("FAIL bp_third_accept: got %0d want 3", n_acc); end
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
        n_cmp++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            n_bad++; $display("FAIL bp_count: got %0d beats want 3 (model %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat = got_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (beat !== {1'b1, want}) begin n_bad++; $display("FAIL bp_payload: got %h want %h", beat, {1'b1, want}); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_oob();
        logic [DW:0] beat;
        logic [DW-1:0] want;
        int n_acc;
        do_write(2'd0, 64'hA0A0_0000_0000_00A0);
        do_write(2'd1, 64'hA1A1_0000_0000_00A1);
        do_write(2'd2, 64'hA2A2_0000_0000_00A2);
        n_cmp++;
        if (err_oob !== 1'b0) begin n_bad++; $display("FAIL oob_pre: got %b want 0", err_oob); end
        req_valid = 1'b1; req_data = 2'd3;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (obs_rd !== 1'b1 || err_oob !== 1'b1) begin
            n_bad++; $display("FAIL oob_read_flag: got accept %b err %b want 1 1", obs_rd, err_oob);
        end
        do_write(2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        n_cmp++;
        if (obs_wr !== 1'b1) begin n_bad++; $display("FAIL oob_wr_accept: got %b want 1", obs_wr); end
        n_acc = 0; req_valid = 1'b1; req_data = 2'd0;
        for (int i = 0; i < 20 && n_acc < 3; i++) begin
            step();
            if (obs_rd) begin
                n_acc++;
                req_data = AW'(n_acc);
            end
        end
        req_valid = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
        n_cmp++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_bad++; $display("FAIL oob_count: got %0d beats want 4 (model %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat = got_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (beat !== {1'b1, want}) begin n_bad++; $display("FAIL oob_payload: got %h want %h", beat, {1'b1, want}); end
        end
        got_q.delete(); exp_q.delete();
        n_cmp++;
        if (err_oob !== 1'b1) begin n_bad++; $display("FAIL oob_sticky: got %b want 1", err_oob); end
    endtask

    task automatic test_reset_midop();
        logic [DW:0] beat;
        logic [DW-1:0] want;
        logic a0, a1;
        do_write(2'd1, 64'h1234_5678_9ABC_DEF0);
        pl_ready = 1'b0; req_valid = 1'b1; req_data = 2'd0;
        step(); a0 = obs_rd;
        req_data = 2'd2;
        step(); a1 = obs_rd;
        req_valid = 1'b0;
        n_cmp++;
        if ({a0, a1, pl_valid} !== 3'b111) begin
            n_bad++; $display("FAIL midop_setup: got acc/acc/tvalid %b want 111", {a0, a1, pl_valid});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        n_cmp++;
        if (pl_valid !== 1'b0 || pl_data !== '0) begin
            n_bad++; $display("FAIL midop_tvalid: got %b data %h want 0 0", pl_valid, pl_data);
        end
        n_cmp++;
        if (err_oob !== 1'b0) begin n_bad++; $display("FAIL midop_err_oob: got %b want 0", err_oob); end
        pl_ready = 1'b1;
        repeat (4) step();
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL midop_stray_beats: got %0d want 0", got_q.size()); end
        got_q.delete();
        req_valid = 1'b1; req_data = 2'd1;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++; $display("FAIL midop_count: got %0d beats want 1 (model %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            beat = got_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (beat !== {1'b1, want}) begin n_bad++; $display("FAIL midop_payload: got %h want %h", beat, {1'b1, want}); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_starvation();
        test_backpressure();
        test_oob();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
